pixel_stream_proc: RTL

- Parametrised streaming RGB pixel processor; next generation of the frame-read/point-operation path.
- Accepts one RGB pixel per beat on a valid/ready input stream and applies a runtime-selected point operation: pass, brightness add/sub, grayscale, invert or threshold.
- Emits the result on a valid/ready output stream with start-of-frame, end-of-line and end-of-frame markers.
- Frame geometry and mode are latched per frame; sits between the frame-memory reader and the display/file-writer sinks.

---
 rtl/pixel_stream_proc.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/pixel_stream_proc.sv
// Streaming RGB point-operation processor with frame/line markers.
// Define GRAY_WEIGHTED_EN for luma-weighted grayscale and threshold.
module pixel_stream_proc #(
  parameter int DW    = 8,
  parameter int MAX_W = 4096,
  parameter int MAX_H = 4096
) (
  input  logic                     HCLK,
  input  logic                     HRESETn,
  input  logic                     start,
  input  logic [$clog2(MAX_W):0]   cfg_width,
  input  logic [$clog2(MAX_H):0]   cfg_height,
  input  logic [2:0]               cfg_mode,
  input  logic [DW-1:0]            cfg_value,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [3*DW-1:0]          s_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [3*DW-1:0]          m_data,
  output logic                     m_sof,
  output logic                     m_eol,
  output logic                     m_eof,
  output logic                     busy,
  output logic                     done
);
  localparam int CW = $clog2(MAX_W);
  localparam int RW = $clog2(MAX_H);
  localparam logic [CW:0] ONE_W = (CW+1)'(1);
  localparam logic [RW:0] ONE_H = (RW+1)'(1);
  localparam logic [DW+1:0] MAXV = {2'b00, {DW{1'b1}}};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic [CW:0]     width_q, width_d;
  logic [RW:0]     height_q, height_d;
  logic [2:0]      mode_q, mode_d;
  logic [DW-1:0]   value_q, value_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic            v1_q, v1_d;
  logic [3*DW-1:0] d1_q, d1_d;
  logic            sof1_q, sof1_d;
  logic            eol1_q, eol1_d;
  logic            eof1_q, eof1_d;

  logic            mv_q, mv_d;
  logic [3*DW-1:0] md_q, md_d;
  logic            msof_q, msof_d;
  logic            meol_q, meol_d;
  logic            meof_q, meof_d;

  logic adv1, adv2, in_hs, out_hs;
  logic last_col, last_row;

  function automatic logic [DW-1:0] gray_of(input logic [3*DW-1:0] p);
`ifdef GRAY_WEIGHTED_EN
    logic [DW+17:0] acc;
    acc = (DW+18)'(p[3*DW-1:2*DW]) * (DW+18)'(77)
        + (DW+18)'(p[2*DW-1:DW]) * (DW+18)'(150)
        + (DW+18)'(p[DW-1:0]) * (DW+18)'(29);
    return DW'(acc >> 8);
`else
    logic [DW+1:0] acc;
    acc = (DW+2)'(p[3*DW-1:2*DW])
        + (DW+2)'(p[2*DW-1:DW])
        + (DW+2)'(p[DW-1:0]);
    return DW'(acc / (DW+2)'(3));
`endif
  endfunction

  function automatic logic [3*DW-1:0] point_op(
    input logic [2:0]      mode,
    input logic [DW-1:0]   val,
    input logic [3*DW-1:0] p
  );
    logic [DW+1:0]   c, v, t;
    logic [DW-1:0]   g;
    logic [3*DW-1:0] o;
    o = p;
    v = (DW+2)'(val);
    g = gray_of(p);
    for (int i = 0; i < 3; i++) begin
      c = (DW+2)'(p[i*DW +: DW]);
      case (mode)
        3'd1: t = (c + v > MAXV) ? MAXV : c + v;
        3'd2: t = (c > v) ? c - v : '0;
        3'd3: t = (DW+2)'(g);
        3'd4: t = MAXV - c;
        3'd5: t = ((DW+2)'(g) > v) ? MAXV : '0;
        default: t = c;
      endcase
      o[i*DW +: DW] = DW'(t);
    end
    return o;
  endfunction

  assign adv2     = !mv_q || m_ready;
  assign adv1     = !v1_q || adv2;
  assign s_ready  = (state_q == RUN) && adv1;
  assign in_hs    = s_valid && s_ready;
  assign out_hs   = mv_q && m_ready;
  assign last_col = ({1'b0, col_q} == width_q - ONE_W);
  assign last_row = ({1'b0, row_q} == height_q - ONE_H);

  // Frame FSM: latch config on start, count input beats, wait for eof drain.
  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    width_d  = width_q;
    height_d = height_q;
    mode_d   = mode_q;
    value_d  = value_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && (|cfg_width) && (|cfg_height)) begin
          width_d  = cfg_width;
          height_d = cfg_height;
          mode_d   = cfg_mode;
          value_d  = cfg_value;
          col_d    = '0;
          row_d    = '0;
          busy_d   = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (in_hs) begin
          if (last_col) begin
            col_d = '0;
            if (last_row) state_d = DRAIN;
            else          row_d = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (out_hs && meof_q) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Two-stage pipeline: stage 1 captures pixel+markers, stage 2 computes.
  always_comb begin
    v1_d   = v1_q;
    d1_d   = d1_q;
    sof1_d = sof1_q;
    eol1_d = eol1_q;
    eof1_d = eof1_q;
    mv_d   = mv_q;
    md_d   = md_q;
    msof_d = msof_q;
    meol_d = meol_q;
    meof_d = meof_q;
    if (adv1) begin
      v1_d = in_hs;
      if (in_hs) begin
        d1_d   = s_data;
        sof1_d = (row_q == '0) && (col_q == '0);
        eol1_d = last_col;
        eof1_d = last_col && last_row;
      end
    end
    if (adv2) begin
      mv_d = v1_q;
      if (v1_q) begin
        md_d   = point_op(mode_q, value_q, d1_q);
        msof_d = sof1_q;
        meol_d = eol1_q;
        meof_d = eof1_q;
      end
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q  <= IDLE;
      col_q    <= '0;
      row_q    <= '0;
      width_q  <= '0;
      height_q <= '0;
      mode_q   <= '0;
      value_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      v1_q     <= 1'b0;
      d1_q     <= '0;
      sof1_q   <= 1'b0;
      eol1_q   <= 1'b0;
      eof1_q   <= 1'b0;
      mv_q     <= 1'b0;
      md_q     <= '0;
      msof_q   <= 1'b0;
      meol_q   <= 1'b0;
      meof_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      row_q    <= row_d;
      width_q  <= width_d;
      height_q <= height_d;
      mode_q   <= mode_d;
      value_q  <= value_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      v1_q     <= v1_d;
      d1_q     <= d1_d;
      sof1_q   <= sof1_d;
      eol1_q   <= eol1_d;
      eof1_q   <= eof1_d;
      mv_q     <= mv_d;
      md_q     <= md_d;
      msof_q   <= msof_d;
      meol_q   <= meol_d;
      meof_q   <= meof_d;
    end
  end

  assign m_valid = mv_q;
  assign m_data  = md_q;
  assign m_sof   = msof_q;
  assign m_eol   = meol_q;
  assign m_eof   = meof_q;
  assign busy    = busy_q;
  assign done    = done_q;
endmodule
